// File: rtl/aes_pkg.sv
// Shared AES constants, FSM state type and S-box tables for the SubBytes stage.
package aes_pkg;

  localparam int unsigned NB_BYTES      = 16;
  localparam int unsigned NB_COLS       = 4;
  localparam int unsigned BYTE_W        = 8;
  localparam int unsigned BYTES_PER_COL = NB_BYTES / NB_COLS;
  localparam int unsigned COL_W         = BYTES_PER_COL * BYTE_W;
  localparam int unsigned STATE_W       = NB_BYTES * BYTE_W;
  localparam int unsigned COL_IDX_W     = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Forward S-box, indexed by input byte
  localparam logic [7:0] FWD_SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Inverse S-box, indexed by substituted byte
  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

endpackage

// File: rtl/aes_sbox.sv
// Combinational single-byte S-box lookup.
// SUBBYTES_INV_SBOX_EN adds i_inv to select the inverse table.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [BYTE_W-1:0] i_byte,
`ifdef SUBBYTES_INV_SBOX_EN
  input  logic              i_inv,
`endif
  output logic [BYTE_W-1:0] o_byte_c
);

`ifdef SUBBYTES_INV_SBOX_EN
  // Table select follows the direction latched for the whole block
  assign o_byte_c = i_inv ? INV_SBOX[i_byte] : FWD_SBOX[i_byte];
`else
  // Forward-only lookup
  assign o_byte_c = FWD_SBOX[i_byte];
`endif

endmodule

// File: rtl/subbytes_iter128.sv
// Iterative AES SubBytes: one 32-bit column per clock through 4 S-boxes,
// valid/ready on both sides. SUBBYTES_INV_SBOX_EN adds the in_inv input
// selecting the inverse S-box for the whole block.
module subbytes_iter128
  import aes_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [0:STATE_W-1] in_state,
`ifdef SUBBYTES_INV_SBOX_EN
  input  logic               in_inv,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [0:STATE_W-1] out_state,
  output logic               busy
);

  state_t                 r_state;
  logic [COL_IDX_W-1:0]   r_col;
  logic [0:STATE_W-1]     r_work;
  logic                   r_out_valid;
  logic                   r_busy;
`ifdef SUBBYTES_INV_SBOX_EN
  logic                   r_inv;
`endif

  logic                   w_accept;
  logic [6:0]             w_col_base;
  logic [0:COL_W-1]       w_col_in;
  logic [0:COL_W-1]       w_col_out;

  // Ready when idle, or when the finished result is being drained this cycle
  assign in_ready   = (r_state == IDLE) || ((r_state == DONE) && out_ready);
  assign w_accept   = in_valid && in_ready;

  // Column currently being substituted
  assign w_col_base = {r_col, 5'b0};
  assign w_col_in   = r_work[w_col_base +: COL_W];

  for (genvar b = 0; b < BYTES_PER_COL; b++) begin : g_sbox
    aes_sbox u_sbox (
      .i_byte   (w_col_in[BYTE_W*b +: BYTE_W]),
`ifdef SUBBYTES_INV_SBOX_EN
      .i_inv    (r_inv),
`endif
      .o_byte_c (w_col_out[BYTE_W*b +: BYTE_W])
    );
  end

  // Control FSM and working register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_col       <= '0;
      r_work      <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
`ifdef SUBBYTES_INV_SBOX_EN
      r_inv       <= 1'b0;
`endif
    end else if (w_accept) begin
      r_state     <= RUN;
      r_col       <= '0;
      r_work      <= in_state;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b1;
`ifdef SUBBYTES_INV_SBOX_EN
      r_inv       <= in_inv;
`endif
    end else begin
      case (r_state)
        RUN: begin
          r_work[w_col_base +: COL_W] <= w_col_out;
          if (r_col == COL_IDX_W'(NB_COLS - 1)) begin
            // Column index parks at the last column until the next accept
            r_state     <= DONE;
            r_out_valid <= 1'b1;
            r_busy      <= 1'b0;
          end else begin
            r_col <= r_col + COL_IDX_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
          end
        end
        IDLE: begin
        end
        default: begin
          r_state     <= IDLE;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign out_state = r_work;
  assign busy      = r_busy;

endmodule

// File: doc/subbytes_iter128.md
SUBBYTES_ITER128 -- requirements
Module: subbytes_iter128

Interface
REQ-001 SHALL have port clk, input, 1 bit: single rising-edge clock.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port in_valid, input, 1 bit: in_state is valid.
REQ-004 SHALL have port in_ready, output, 1 bit: block can accept a state.
REQ-005 SHALL have port in_state, input, [0:127]: AES state; byte k = bits 8k..8k+7, column c = bytes 4c..4c+3.
REQ-006 SHALL have port out_valid, output, 1 bit: out_state holds a substituted result.
REQ-007 SHALL have port out_ready, input, 1 bit: downstream stage (ShiftRows) consumes the result.
REQ-008 SHALL have port out_state, output, [0:127]: SubBytes result, same byte ordering as in_state, fed directly to the ShiftRows stage.
REQ-009 SHALL have port busy, output, 1 bit: high in RUN state.

Function
REQ-010 SHALL implement FSM states IDLE, RUN, DONE plus a 2-bit column counter col.
REQ-011 in_ready SHALL equal (state==IDLE) or (state==DONE and out_ready).
REQ-012 On an edge with in_valid and in_ready high, SHALL capture in_state into the working register, set col=0, and enter RUN.
REQ-013 In RUN, each edge SHALL replace column col (bits 32col..32col+31) with the S-box of each of its 4 bytes, then increment col.
REQ-014 On the RUN edge with col==3, SHALL enter DONE; no other column is modified on that edge.
REQ-015 out_valid SHALL be high exactly in DONE; latency is 4 clock edges from the accepting edge to out_valid high.
REQ-016 out_state SHALL be the working register and SHALL stay stable while out_valid is high and out_ready is low.
REQ-017 In DONE with out_ready high: SHALL go to IDLE if in_valid is low; SHALL accept the new state and enter RUN if in_valid is high (back-to-back, 5-cycle interval).
REQ-018 in_valid SHALL be ignored in RUN; in_state changes there SHALL NOT affect the result.
REQ-019 Columns not yet processed SHALL hold input bytes; col SHALL wrap from 3 to 0 only via a new accept.

Reset
REQ-020 Asserting rst_n low SHALL immediately force IDLE, col=0, working register=0, out_valid=0, busy=0, in_ready=1, regardless of clock.
REQ-021 Reset during RUN or DONE SHALL discard the in-flight block; no out_valid SHALL follow.

Configuration
REQ-022 Macro SUBBYTES_INV_SBOX_EN defined: SHALL add input in_inv (1 bit), captured at accept; the block SHALL use the inverse S-box for the whole block when in_inv was 1.
REQ-023 Macro undefined: SHALL have no in_inv port and forward S-box only; timing is identical.

Structure
REQ-024 Shared package aes_pkg SHALL hold the byte/column count constants (16 bytes, 4 columns), the FSM state typedef and the forward and inverse S-box tables.
REQ-025 SHALL instantiate 4 copies of sub-module aes_sbox (8-bit in, 8-bit out, combinational, inv select when SUBBYTES_INV_SBOX_EN).

Verification
REQ-026 All-zero in_state accepted, out_ready=1 -> out_valid 4 edges later, out_state = 16 bytes of 0x63.
REQ-027 in_state 00112233445566778899aabbccddeeff -> out_state 638293c31bfc33f5c4eeacea4bc12816.
REQ-028 out_ready held low 10 cycles in DONE -> out_valid and out_state stable, in_ready=0; release -> single handshake, return to IDLE.
REQ-029 Two blocks with in_valid and out_ready held high -> second accepted on the DONE edge, outputs spaced 5 cycles, both correct.
REQ-030 rst_n pulsed low at col==2 -> outputs cleared asynchronously, no out_valid, next block processes correctly.
REQ-031 With SUBBYTES_INV_SBOX_EN and in_inv=1, in_state 16 x 0x63 -> out_state all zero.
